// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader: controller states,
// skid buffer depth and the issue-room helper.
package fifo_burst_reader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SKID_DEPTH = 2;
   localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

   // True when a word issued now still fits once the in-flight word lands.
   function automatic logic has_room(input logic [OCC_W-1:0] occupancy,
                                     input logic             inflight,
                                     input logic             pop);
      return (int'(occupancy) + int'(inflight) - int'(pop)) < SKID_DEPTH;
   endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Valid/ready output stream carrying signed words and a last-word marker.
interface fifo_burst_reader_if #(
   parameter int WIDTH = 16
);
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] out_data;
   logic                    out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/fifo_burst_reader_skid.sv
// Two-entry skid buffer: entry 0 is the head, pops shift the queue forward and
// a push lands in the first free slot after any same-cycle pop.
module fifo_burst_reader_skid
   import fifo_burst_reader_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             rd_clk,
   input  logic             rd_rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [OCC_W-1:0] occupancy,
   output logic [WIDTH-1:0] head
);

   logic [SKID_DEPTH-1:0][WIDTH-1:0] data_reg;
   logic [SKID_DEPTH-1:0][WIDTH-1:0] data_next;
   logic [OCC_W-1:0]                 count_reg;
   logic [OCC_W-1:0]                 count_next;
   logic [OCC_W-1:0]                 count_kept;
   logic                             do_pop;
   logic                             do_push;

   // Pop is resolved first so a push into a full buffer that is also popping succeeds.
   always_comb begin
      do_pop     = pop && (count_reg != '0);
      count_kept = count_reg - OCC_W'(do_pop);
      do_push    = push && (count_kept < OCC_W'(SKID_DEPTH));
      count_next = count_kept + OCC_W'(do_push);
   end

   genvar gi;
   generate
      for (gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
         logic [WIDTH-1:0] shifted;
         if (gi < SKID_DEPTH - 1) begin : g_shift
            assign shifted = do_pop ? data_reg[gi + 1] : data_reg[gi];
         end else begin : g_tail
            assign shifted = data_reg[gi];
         end
         assign data_next[gi] = (do_push && (count_kept == OCC_W'(gi))) ? push_data : shifted;
      end
   endgenerate

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         data_reg  <= '0;
         count_reg <= '0;
      end else begin
         data_reg  <= data_next;
         count_reg <= count_next;
      end
   end

   assign occupancy = count_reg;
   assign head      = data_reg[0];

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read controller draining a programmed number of FIFO words into a
// valid/ready stream. Optional stall counter under FIFO_BURST_READER_STATS_EN.
module fifo_burst_reader
   import fifo_burst_reader_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LEN_W = 9
) (
   input  logic                    rd_clk,
   input  logic                    rd_rst_n,
   input  logic                    rd_start,
   input  logic [LEN_W-1:0]        rd_len,
   output logic                    rd_busy,
   output logic                    rd_done,
   output logic                    fifo_re,
   input  logic                    fifo_empty,
   input  logic signed [WIDTH-1:0] fifo_out,
   fifo_burst_reader_if.master     stream
`ifdef FIFO_BURST_READER_STATS_EN
   ,
   output logic [15:0]             rd_stall_cnt
`endif
);

   state_t           state_reg;
   state_t           state_next;
   logic [LEN_W-1:0] len_reg;
   logic [LEN_W-1:0] len_next;
   logic [LEN_W-1:0] issued_reg;
   logic [LEN_W-1:0] issued_next;
   logic [LEN_W-1:0] delivered_reg;
   logic [LEN_W-1:0] delivered_next;
   logic             inflight_reg;
   logic [OCC_W-1:0] occupancy;
   logic [WIDTH-1:0] head;
   logic             pop;
   logic             last_word;
   logic             want_more;

   // The word read last cycle arrives on fifo_out now and enters the skid tail.
   fifo_burst_reader_skid #(
      .WIDTH (WIDTH)
   ) u_skid (
      .rd_clk    (rd_clk),
      .rd_rst_n  (rd_rst_n),
      .push      (inflight_reg),
      .push_data (fifo_out),
      .pop       (pop),
      .occupancy (occupancy),
      .head      (head)
   );

   assign stream.out_valid = (occupancy != '0);
   assign stream.out_data  = head;
   assign pop              = stream.out_valid && stream.out_ready;
   assign last_word        = (delivered_reg == len_reg - 1'b1);
   assign stream.out_last  = stream.out_valid && last_word;
   assign want_more        = (issued_reg < len_reg);

   assign fifo_re = (state_reg == READ) && !fifo_empty && want_more
                    && has_room(occupancy, inflight_reg, pop);

   assign rd_busy = (state_reg != IDLE);
   assign rd_done = (state_reg == DONE);

   always_comb begin
      state_next     = state_reg;
      len_next       = len_reg;
      issued_next    = issued_reg;
      delivered_next = delivered_reg;
      if (fifo_re) begin
         issued_next = issued_reg + 1'b1;
      end
      if (pop) begin
         delivered_next = delivered_reg + 1'b1;
      end
      case (state_reg)
         IDLE: begin
            if (rd_start) begin
               len_next       = rd_len;
               issued_next    = '0;
               delivered_next = '0;
               state_next     = (rd_len == '0) ? DONE : READ;
            end
         end
         READ: begin
            if (pop && last_word) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         state_reg     <= IDLE;
         len_reg       <= '0;
         issued_reg    <= '0;
         delivered_reg <= '0;
         inflight_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         len_reg       <= len_next;
         issued_reg    <= issued_next;
         delivered_reg <= delivered_next;
         inflight_reg  <= fifo_re;
      end
   end

`ifdef FIFO_BURST_READER_STATS_EN
   logic [15:0] stall_cnt_reg;
   logic [15:0] stall_cnt_next;

   // Counts cycles the burst wants data but the FIFO has none; saturates.
   always_comb begin
      stall_cnt_next = stall_cnt_reg;
      if ((state_reg == IDLE) && rd_start) begin
         stall_cnt_next = '0;
      end else if ((state_reg == READ) && fifo_empty && want_more
                   && (stall_cnt_reg != 16'hFFFF)) begin
         stall_cnt_next = stall_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         stall_cnt_reg <= '0;
      end else begin
         stall_cnt_reg <= stall_cnt_next;
      end
   end

   assign rd_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural FIFO model and a
// stream monitor; stall-counter checks apply when FIFO_BURST_READER_STATS_EN is set.
module tb_fifo_burst_reader;
   localparam int WIDTH = 16;
   localparam int LEN_W = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    rst_n;
   logic                    start;
   logic [LEN_W-1:0]        len;
   logic                    busy;
   logic                    done;
   logic                    fifo_re;
   logic                    fifo_empty;
   logic signed [WIDTH-1:0] fifo_out = '0;
`ifdef FIFO_BURST_READER_STATS_EN
   logic [15:0]             stall_cnt;
`endif

   fifo_burst_reader_if #(.WIDTH(WIDTH)) sif ();

   fifo_burst_reader #(
      .WIDTH (WIDTH),
      .LEN_W (LEN_W)
   ) dut (
      .rd_clk       (clk),
      .rd_rst_n     (rst_n),
      .rd_start     (start),
      .rd_len       (len),
      .rd_busy      (busy),
      .rd_done      (done),
      .fifo_re      (fifo_re),
      .fifo_empty   (fifo_empty),
      .fifo_out     (fifo_out),
      .stream       (sif.master)
`ifdef FIFO_BURST_READER_STATS_EN
      ,
      .rd_stall_cnt (stall_cnt)
`endif
   );

   int vec_cnt = 0;
   int err_cnt = 0;

   // FIFO model: one-cycle read latency, never reset.
   logic signed [WIDTH-1:0] fmem [256];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_re) begin
         fifo_out <= fmem[rd_ptr % 256];
         rd_ptr   <= rd_ptr + 1;
      end
   end

   // Monitor: settled values at the falling edge are what the next rising edge samples.
   int re_cnt = 0;
   int re_empty_cnt = 0;
   int done_cnt = 0;
   int cap_n = 0;
   logic signed [WIDTH-1:0] cap_data [256];
   logic                    cap_last [256];

   always @(negedge clk) begin
      if (fifo_re === 1'b1) re_cnt++;
      if (fifo_re === 1'b1 && fifo_empty) re_empty_cnt++;
      if (done === 1'b1) done_cnt++;
      if (sif.out_valid === 1'b1 && sif.out_ready === 1'b1) begin
         cap_data[cap_n % 256] = sif.out_data;
         cap_last[cap_n % 256] = sif.out_last;
         cap_n++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic signed [WIDTH-1:0] v);
      fmem[wr_ptr % 256] = v;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic start_burst(input int n);
      len   = LEN_W'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while (done !== 1'b1 && k < 50) begin
         tick();
         k++;
      end
      vec_cnt++;
      if (done !== 1'b1) begin
         err_cnt++;
         $display("FAIL %s: rd_done=%b after 50 cycles, required 1", name, done);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      len   = '0;
      sif.out_ready = 1'b0;
      tick();
      tick();
      vec_cnt++;
      if ({busy, done, fifo_re, sif.out_valid, sif.out_last} !== 5'b00000) begin
         err_cnt++;
         $display("FAIL reset_flags: busy/done/re/valid/last=%b, required 00000",
                  {busy, done, fifo_re, sif.out_valid, sif.out_last});
      end
      vec_cnt++;
      if (sif.out_data !== 16'sd0) begin
         err_cnt++;
         $display("FAIL reset_data: out_data=%0d, required 0", sif.out_data);
      end
`ifdef FIFO_BURST_READER_STATS_EN
      vec_cnt++;
      if (stall_cnt !== 16'd0) begin
         err_cnt++;
         $display("FAIL reset_stall: rd_stall_cnt=%0d, required 0", stall_cnt);
      end
`endif
      rst_n = 1'b1;
      tick();
   endtask

   // Two words, cycle-exact: re at s0,s1; data at s2,s3; done at s4; idle at s5.
   task automatic test_basic();
      logic       e_re   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       e_v    [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic       e_l    [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic       e_done [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic       e_busy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic signed [WIDTH-1:0] e_d [6] = '{16'sd0, 16'sd0, 16'sd129, 16'sd45, 16'sd0, 16'sd0};
      int b_re;
      int b_done;
      sif.out_ready = 1'b1;
      push(16'sd129);
      push(16'sd45);
      b_re   = re_cnt;
      b_done = done_cnt;
      start_burst(2);
      for (int s = 0; s < 6; s++) begin
         vec_cnt++;
         if (fifo_re !== e_re[s] || sif.out_valid !== e_v[s] || sif.out_last !== e_l[s]
             || done !== e_done[s] || busy !== e_busy[s]
             || (e_v[s] && sif.out_data !== e_d[s])) begin
            err_cnt++;
            $display("FAIL basic_s%0d: re/valid/last/done/busy=%b%b%b%b%b data=%0d, required %b%b%b%b%b data=%0d",
                     s, fifo_re, sif.out_valid, sif.out_last, done, busy, sif.out_data,
                     e_re[s], e_v[s], e_l[s], e_done[s], e_busy[s], e_d[s]);
         end
         if (s < 5) tick();
      end
      vec_cnt++;
      if (re_cnt - b_re !== 2 || done_cnt - b_done !== 1) begin
         err_cnt++;
         $display("FAIL basic_counts: re pulses=%0d done cycles=%0d, required 2 and 1",
                  re_cnt - b_re, done_cnt - b_done);
      end
   endtask

   // Eight words at full rate: valid s2..s9, last at s9, done at s10.
   task automatic test_stream8();
      logic signed [WIDTH-1:0] w [8] = '{16'sd100, -16'sd1, 16'sd32767, -16'sd32768,
                                         16'sd0, 16'sd5, -16'sd77, 16'sd1234};
      logic signed [WIDTH-1:0] ed;
      logic ev;
      logic el;
      logic ere;
      for (int i = 0; i < 8; i++) push(w[i]);
      sif.out_ready = 1'b1;
      start_burst(8);
      for (int s = 0; s <= 10; s++) begin
         ev  = (s >= 2 && s <= 9);
         el  = (s == 9);
         ere = (s < 8);
         ed  = ev ? w[(s >= 2) ? s - 2 : 0] : 16'sd0;
         vec_cnt++;
         if (sif.out_valid !== ev || sif.out_last !== el || fifo_re !== ere
             || done !== (s == 10) || (ev && sif.out_data !== ed)) begin
            err_cnt++;
            $display("FAIL stream8_s%0d: valid/last/re/done=%b%b%b%b data=%0d, required %b%b%b%b data=%0d",
                     s, sif.out_valid, sif.out_last, fifo_re, done, sif.out_data,
                     ev, el, ere, (s == 10), ed);
         end
         if (s < 10) tick();
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic signed [WIDTH-1:0] w [4] = '{16'sd11, -16'sd22, 16'sd33, 16'sd44};
      int b_re;
      int b_cap;
      for (int i = 0; i < 4; i++) push(w[i]);
      sif.out_ready = 1'b0;
      b_re  = re_cnt;
      b_cap = cap_n;
      start_burst(4);
      for (int s = 0; s <= 5; s++) begin
         vec_cnt++;
         if (fifo_re !== (s < 2) || sif.out_valid !== (s >= 2)
             || (s >= 2 && sif.out_data !== w[0])) begin
            err_cnt++;
            $display("FAIL bp_hold_s%0d: re=%b valid=%b data=%0d, required re=%b valid=%b data=%0d",
                     s, fifo_re, sif.out_valid, sif.out_data, (s < 2), (s >= 2), w[0]);
         end
         if (s < 5) tick();
      end
      vec_cnt++;
      if (re_cnt - b_re !== 2) begin
         err_cnt++;
         $display("FAIL bp_inflight: re pulses while stalled=%0d, required 2", re_cnt - b_re);
      end
      sif.out_ready = 1'b1;
      wait_done("bp_done");
      vec_cnt++;
      if (cap_n - b_cap !== 4 || re_cnt - b_re !== 4) begin
         err_cnt++;
         $display("FAIL bp_count: words=%0d re=%0d, required 4 and 4", cap_n - b_cap, re_cnt - b_re);
      end
      for (int i = 0; i < 4; i++) begin
         vec_cnt++;
         if (cap_data[(b_cap + i) % 256] !== w[i] || cap_last[(b_cap + i) % 256] !== (i == 3)) begin
            err_cnt++;
            $display("FAIL bp_word%0d: data=%0d last=%b, required data=%0d last=%b", i,
                     cap_data[(b_cap + i) % 256], cap_last[(b_cap + i) % 256], w[i], (i == 3));
         end
      end
      tick();
   endtask

   task automatic test_empty_stall();
      logic signed [WIDTH-1:0] w [3] = '{16'sd7, -16'sd8, 16'sd9};
      int b_cap;
      push(w[0]);
      sif.out_ready = 1'b1;
      b_cap = cap_n;
      start_burst(3);
      for (int k = 0; k < 10; k++) tick();
      vec_cnt++;
      if (cap_n - b_cap !== 1 || busy !== 1'b1 || done !== 1'b0) begin
         err_cnt++;
         $display("FAIL stall_wait: words=%0d busy=%b done=%b, required 1, 1, 0",
                  cap_n - b_cap, busy, done);
      end
`ifdef FIFO_BURST_READER_STATS_EN
      vec_cnt++;
      if (stall_cnt !== 16'd9) begin
         err_cnt++;
         $display("FAIL stall_cnt_wait: rd_stall_cnt=%0d, required 9", stall_cnt);
      end
`endif
      push(w[1]);
      push(w[2]);
      wait_done("stall_done");
      vec_cnt++;
      if (cap_n - b_cap !== 3) begin
         err_cnt++;
         $display("FAIL stall_count: words=%0d, required 3", cap_n - b_cap);
      end
      for (int i = 0; i < 3; i++) begin
         vec_cnt++;
         if (cap_data[(b_cap + i) % 256] !== w[i] || cap_last[(b_cap + i) % 256] !== (i == 2)) begin
            err_cnt++;
            $display("FAIL stall_word%0d: data=%0d last=%b, required data=%0d last=%b", i,
                     cap_data[(b_cap + i) % 256], cap_last[(b_cap + i) % 256], w[i], (i == 2));
         end
      end
`ifdef FIFO_BURST_READER_STATS_EN
      vec_cnt++;
      if (stall_cnt !== 16'd9) begin
         err_cnt++;
         $display("FAIL stall_cnt_end: rd_stall_cnt=%0d, required 9", stall_cnt);
      end
`endif
      tick();
   endtask

   task automatic test_zero_len_and_ignore();
      int b_re;
      int b_cap;
      b_re  = re_cnt;
      b_cap = cap_n;
      sif.out_ready = 1'b1;
      start_burst(0);
      vec_cnt++;
      if (done !== 1'b1 || busy !== 1'b1 || fifo_re !== 1'b0) begin
         err_cnt++;
         $display("FAIL zero_done: done=%b busy=%b re=%b, required 1 1 0", done, busy, fifo_re);
      end
      tick();
      vec_cnt++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         err_cnt++;
         $display("FAIL zero_idle: done=%b busy=%b, required 0 0", done, busy);
      end
      push(16'sd55);
      push(-16'sd66);
      start_burst(2);
      len   = LEN_W'(5);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("ignore_done");
      tick();
      tick();
      vec_cnt++;
      if (busy !== 1'b0 || cap_n - b_cap !== 2 || re_cnt - b_re !== 2) begin
         err_cnt++;
         $display("FAIL ignore_start: busy=%b words=%0d re=%0d, required 0, 2, 2",
                  busy, cap_n - b_cap, re_cnt - b_re);
      end
      vec_cnt++;
      if (cap_data[b_cap % 256] !== 16'sd55 || cap_data[(b_cap + 1) % 256] !== -16'sd66
          || cap_last[(b_cap + 1) % 256] !== 1'b1) begin
         err_cnt++;
         $display("FAIL ignore_words: data=%0d,%0d last=%b, required 55,-66 last=1",
                  cap_data[b_cap % 256], cap_data[(b_cap + 1) % 256], cap_last[(b_cap + 1) % 256]);
      end
   endtask

   task automatic test_reset_mid();
      int b_cap;
      push(16'sd501);
      push(-16'sd502);
      push(16'sd503);
      push(16'sd504);
      sif.out_ready = 1'b0;
      start_burst(4);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      vec_cnt++;
      if ({busy, done, fifo_re, sif.out_valid, sif.out_last} !== 5'b00000 || sif.out_data !== 16'sd0) begin
         err_cnt++;
         $display("FAIL midreset: busy/done/re/valid/last=%b data=%0d, required 00000 data=0",
                  {busy, done, fifo_re, sif.out_valid, sif.out_last}, sif.out_data);
      end
`ifdef FIFO_BURST_READER_STATS_EN
      vec_cnt++;
      if (stall_cnt !== 16'd0) begin
         err_cnt++;
         $display("FAIL midreset_stall: rd_stall_cnt=%0d, required 0", stall_cnt);
      end
`endif
      rst_n = 1'b1;
      tick();
      sif.out_ready = 1'b1;
      b_cap = cap_n;
      start_burst(2);
      wait_done("after_reset_done");
      vec_cnt++;
      if (cap_n - b_cap !== 2 || cap_data[b_cap % 256] !== 16'sd503
          || cap_data[(b_cap + 1) % 256] !== 16'sd504 || cap_last[(b_cap + 1) % 256] !== 1'b1) begin
         err_cnt++;
         $display("FAIL after_reset_words: n=%0d data=%0d,%0d last=%b, required 2, 503,504 last=1",
                  cap_n - b_cap, cap_data[b_cap % 256], cap_data[(b_cap + 1) % 256],
                  cap_last[(b_cap + 1) % 256]);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stream8();
      test_backpressure();
      test_empty_stall();
      test_zero_len_and_ignore();
      test_reset_mid();
      vec_cnt++;
      if (re_empty_cnt !== 0) begin
         err_cnt++;
         $display("FAIL re_while_empty: cycles=%0d, required 0", re_empty_cnt);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Burst read controller that sits directly downstream of the on-chip `fifo` and drains a programmed number of words from it into a valid/ready stream toward the systolic array feed path. It issues `fifo_re` only when the FIFO is non-empty and downstream space is guaranteed. It absorbs the FIFO's one-cycle read latency with a 2-entry skid buffer, so no word is ever dropped. It flags the final word of each burst and pulses completion.

## Interface
- `WIDTH`, 16: data width, matches the FIFO `WIDTH`.
- `LEN_W`, 9: burst length width; 256-word FIFO drains in one burst.
- `rd_clk`  in  1  single clock, rising edge.
- `rd_rst_n`  in  1  reset, synchronous, active-low.
- `rd_start`  in  1  starts a burst when sampled high in IDLE.
- `rd_len`  in  LEN_W  burst length, sampled with `rd_start`.
- `rd_busy`  out  1  high from the cycle after accepted start until DONE exits.
- `rd_done`  out  1  one-cycle pulse after the last word handshakes.
- `fifo_re`  out  1  FIFO read enable.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_out`  in  WIDTH signed  FIFO read data, valid the cycle after `fifo_re` is sampled.
- `out_valid`  out  1  stream data valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  WIDTH signed  stream data.
- `out_last`  out  1  qualifies the final word of a burst.
- `rd_stall_cnt`  out  16  exists only with `FIFO_BURST_READER_STATS_EN`.

## Operation
- States: IDLE, READ, DONE.
- IDLE → READ: on `rd_start` with `rd_len` ≠ 0. Latch `rd_len`, clear the issued and delivered counters.
- IDLE → DONE: on `rd_start` with `rd_len` = 0. No `fifo_re` is issued.
- READ → DONE: on the cycle the delivered count reaches len, i.e. the handshake of the `out_last` word.
- DONE → IDLE: unconditionally after one cycle. `rd_done` is high during DONE.
- `rd_start` is ignored outside IDLE.
- Issue rule: `fifo_re` = READ ∧ ¬`fifo_empty` ∧ issued < len ∧ (skid occupancy + in-flight − pop) < 2.
  - in-flight = `fifo_re` of the previous cycle.
  - pop = `out_valid` ∧ `out_ready`.
  - This is a combinational path from `out_ready` to `fifo_re`.
- `fifo_re` is never asserted while `fifo_empty` is high.
- The in-flight word is written into the skid tail on the following edge.
- `out_valid` = skid non-empty. `out_data` is the skid head.
- `out_last` = `out_valid` ∧ (delivered = len − 1).
- Data passes through unmodified; signed width is preserved.
- Reset mid-burst: all state clears. A word already read from the FIFO is discarded.

## Timing
- Reset values (`rd_rst_n` low at an edge): state IDLE; `rd_busy`, `rd_done`, `fifo_re`, `out_valid`, `out_last` = 0; `out_data` = 0; counters = 0; `rd_stall_cnt` = 0.
- `rd_start` sampled at edge 0 → `fifo_re` may be high in cycle 1 → `fifo_out` valid in cycle 2 → `out_valid` high in cycle 3.
- Steady state with `out_ready` = 1 and the FIFO non-empty: one word per cycle.
- Backpressure: at most 2 words are buffered or in flight. Held data stays stable while `out_valid` ∧ ¬`out_ready`.
- FIFO empty mid-burst: the burst waits indefinitely, with `rd_busy` held high.
- `rd_done` is high in the cycle after the `out_last` handshake.

## Configuration
- `FIFO_BURST_READER_STATS_EN` defined:
  - `rd_stall_cnt` increments each READ cycle with `fifo_empty` ∧ issued < len.
  - It saturates at 0xFFFF and clears on an accepted `rd_start`.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Structure
- `fifo_burst_reader_pkg`: state enum (IDLE/READ/DONE) and constant `SKID_DEPTH` = 2.
- Sub-module `fifo_burst_reader_skid`:
  - 2-entry buffer with push, pop, occupancy, head data.
  - Simultaneous push and pop when full or empty is legal.
- The controller FSM, counters and issue logic live in the top module.

## Test plan
- FIFO holds 129, 45; `rd_len` = 2; `out_ready` = 1 → `out_data` 129 then 45, `out_last` on 45, `rd_done` pulse next cycle, exactly 2 `fifo_re` cycles.
- 8 words preloaded, `rd_len` = 8, `out_ready` = 1 → 8 consecutive valid cycles, first `out_valid` 3 cycles after start.
- `rd_len` = 4, `out_ready` low for 5 cycles after start → at most 2 `fifo_re` pulses, `out_data` stable, all 4 words delivered in order after release.
- `rd_len` = 3 with 1 word in the FIFO → 1 word out, `rd_busy` held, `rd_stall_cnt` counts (stats build); write 2 more → burst completes.
- `rd_len` = 0 → `rd_done` pulse, no `fifo_re`. `rd_start` pulsed while busy → ignored.
- `rd_rst_n` low mid-burst → all outputs at reset values next cycle. A new burst then runs correctly.
